idct_8x8_engine: RTL and testbench

- Inverse of the forward 8x8 DCT path: accepts one block of 64 quantised-then-dequantised DCT coefficients and reconstructs 64 8-bit pixels.
- Direct 2D summation on a single MAC. Basis weights come from a combinational basis LUT that is the transpose of the forward cosine LUTs, with normalisation folded in.
- Sits after dequantisation in the decode path and feeds the frame/pixel writer.

---
 rtl/idct_8x8_engine_pkg.sv | 27 ++
 rtl/idct_8x8_engine_if.sv | 48 ++++
 rtl/idct_8x8_engine_basis_lut.sv | 76 +++++++
 rtl/idct_8x8_engine.sv | 162 ++++++++++++++++
 tb/tb_idct_8x8_engine.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/idct_8x8_engine_pkg.sv
// ---------------------------------------------------------------------------
// idct_pkg
// Shared constants and types for the 8x8 inverse DCT engine.
//   IDCT_COEF_W    : default signed coefficient width
//   IDCT_ACC_W     : default signed accumulator width
//   IDCT_FRAC_BITS : fractional bits of the basis weights (Q12)
//   WEIGHT_W       : width of a signed basis weight
//   BLOCK_SIZE     : coefficients / pixels per block
//   LEVEL_SHIFT    : offset added to the reconstructed sample
//   state_t        : engine FSM states
// ---------------------------------------------------------------------------
package idct_pkg;

  localparam int IDCT_COEF_W    = 16;
  localparam int IDCT_ACC_W     = 40;
  localparam int IDCT_FRAC_BITS = 12;
  localparam int WEIGHT_W       = 16;
  localparam int BLOCK_SIZE     = 64;
  localparam int LEVEL_SHIFT    = 128;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    MAC  = 2'd1,
    EMIT = 2'd2
  } state_t;

endpackage

// File: rtl/idct_8x8_engine_if.sv
// ---------------------------------------------------------------------------
// idct_8x8_engine_if
// Coefficient-in / pixel-out streams of the inverse DCT engine.
//   coef_valid, coef_data : coefficient stream from the dequantiser
//   coef_ready            : engine accepts a coefficient
//   pix_valid, pix_data   : reconstructed pixel stream to the pixel writer
//   pix_ready             : pixel writer accepts a pixel
// Modports:
//   master : the side that supplies coefficients and sinks pixels
//   slave  : the engine
//
// Handshake (both streams): a word moves on the rising clock edge where
// valid and ready are both high. Once valid is raised the source holds valid
// and data stable until that edge; ready may change freely and never depends
// on a transfer that has not happened yet.
// ---------------------------------------------------------------------------
interface idct_8x8_engine_if
  import idct_pkg::*;
#(
  parameter int COEF_W = IDCT_COEF_W
);

  logic                     coef_valid;
  logic                     coef_ready;
  logic signed [COEF_W-1:0] coef_data;
  logic                     pix_valid;
  logic                     pix_ready;
  logic [7:0]               pix_data;

  modport master (
    output coef_valid,
    output coef_data,
    input  coef_ready,
    input  pix_valid,
    input  pix_data,
    output pix_ready
  );

  modport slave (
    input  coef_valid,
    input  coef_data,
    output coef_ready,
    output pix_valid,
    output pix_data,
    input  pix_ready
  );

endinterface

// File: rtl/idct_8x8_engine_basis_lut.sv
// ---------------------------------------------------------------------------
// idct_basis_lut
// Combinational 2D inverse DCT basis weight, Q12 signed:
//   weight = round(4096 * a(k1)*a(k2) * cos((2n1+1)k1*pi/16) * cos((2n2+1)k2*pi/16))
//   with a(0) = sqrt(1/8), a(k) = 1/2 otherwise.
// Ports:
//   k1, k2 : frequency indices (row, column)
//   n1, n2 : spatial indices (row, column)
//   weight : signed WEIGHT_W-bit Q12 weight
// The 1D factors come from a Q24 cosine case table (cos(m*pi/16), m=0..8)
// folded by symmetry; the two factors are multiplied at full precision and
// rounded once to Q12, so the result equals rounding the exact product.
// ---------------------------------------------------------------------------
module idct_basis_lut
  import idct_pkg::*;
(
  input  logic [2:0]                 k1,
  input  logic [2:0]                 k2,
  input  logic [2:0]                 n1,
  input  logic [2:0]                 n2,
  output logic signed [WEIGHT_W-1:0] weight
);

  // sqrt(1/8) in Q24
  localparam logic signed [25:0] A0_Q24 = 26'sd5931642;
  // Q48 product -> Q12 weight: add half an LSB, shift by 36
  localparam logic signed [51:0] RND_Q48 = 52'sd34359738368;

  // cos(m*pi/16) in Q24 for any m mod 32.
  function automatic logic signed [25:0] cos_q24(input logic [4:0] m_in);
    logic [4:0]         m;
    logic               neg;
    logic signed [25:0] mag;
    m   = m_in;
    neg = 1'b0;
    // cos(2*pi - x) = cos(x)
    if (m > 5'd16) m = 5'd0 - m;
    // cos(pi - x) = -cos(x)
    if (m > 5'd8) begin
      m   = 5'd16 - m;
      neg = 1'b1;
    end
    case (m)
      5'd0:    mag = 26'sd16777216;
      5'd1:    mag = 26'sd16454846;
      5'd2:    mag = 26'sd15500126;
      5'd3:    mag = 26'sd13949745;
      5'd4:    mag = 26'sd11863283;
      5'd5:    mag = 26'sd9320922;
      5'd6:    mag = 26'sd6420363;
      5'd7:    mag = 26'sd3273072;
      default: mag = '0;
    endcase
    return neg ? -mag : mag;
  endfunction

  // a(k) * cos((2n+1)k*pi/16) in Q24. The angle index wraps mod 32.
  function automatic logic signed [25:0] factor_q24(input logic [2:0] k, input logic [2:0] n);
    logic [4:0] m;
    if (k == 3'd0) return A0_Q24;
    m = 5'({n, 1'b1}) * 5'(k);
    return cos_q24(m) >>> 1;
  endfunction

  logic signed [25:0] f_row;
  logic signed [25:0] f_col;
  logic signed [51:0] prod_q48;

  always_comb begin
    f_row    = factor_q24(k1, n1);
    f_col    = factor_q24(k2, n2);
    prod_q48 = f_row * f_col;
    weight   = WEIGHT_W'((prod_q48 + RND_Q48) >>> 36);
  end

endmodule

// File: rtl/idct_8x8_engine.sv
// ---------------------------------------------------------------------------
// idct_8x8_engine
// Reconstructs an 8x8 block of 8-bit pixels from 64 dequantised DCT
// coefficients by direct 2D summation on a single multiply-accumulator.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of idct_8x8_engine_if (coefficient in, pixel out)
//   busy       : high whenever the engine is not in LOAD
//   dbg_state  : current FSM state
// Flow: LOAD takes 64 coefficients (k1-major). For each output pixel
// (n1-major) MAC runs k = 0..63, one term per cycle, then EMIT registers the
// rounded, level-shifted, clamped result and holds it until the consumer
// takes it. EMIT spends one cycle forming the pixel before pix_valid rises.
// ---------------------------------------------------------------------------
module idct_8x8_engine
  import idct_pkg::*;
#(
  parameter int COEF_W    = IDCT_COEF_W,
  parameter int ACC_W     = IDCT_ACC_W,
  parameter int FRAC_BITS = IDCT_FRAC_BITS
)(
  input  logic               clk,
  input  logic               rst_n,
  idct_8x8_engine_if.slave   bus,
  output logic               busy,
  output state_t             dbg_state
);

  localparam int PROD_W = COEF_W + WEIGHT_W;
  localparam logic [5:0] LAST_IDX = 6'(BLOCK_SIZE - 1);
  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) << (FRAC_BITS - 1);
  localparam logic signed [ACC_W-1:0] LSHIFT   = ACC_W'(LEVEL_SHIFT);
  localparam logic signed [ACC_W-1:0] PIX_MIN  = '0;
  localparam logic signed [ACC_W-1:0] PIX_MAX  = ACC_W'(255);

  state_t                    state;
  state_t                    next_state;
  logic [5:0]                load_idx;
  logic [5:0]                out_idx;
  logic [5:0]                k;
  logic signed [ACC_W-1:0]   acc;
  logic                      pix_valid_q;
  logic [7:0]                pix_data_q;
  logic signed [COEF_W-1:0]  coef_buf [BLOCK_SIZE];

  logic                      coef_ready_c;
  logic                      busy_c;
  logic                      coef_accept;
  logic                      pix_xfer;
  logic signed [WEIGHT_W-1:0] weight;
  logic signed [PROD_W-1:0]  product;
  logic signed [ACC_W-1:0]   product_ext;

  // Round half up, shift out the Q12 fraction, level shift, clamp to 0..255.
  function automatic logic [7:0] to_pixel(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] v;
    v = (a + RND_HALF) >>> FRAC_BITS;
    v = v + LSHIFT;
    if (v < PIX_MIN) return 8'd0;
    if (v > PIX_MAX) return 8'd255;
    return v[7:0];
  endfunction

  // Frequency index comes from the MAC counter, spatial index from the
  // current output pixel.
  idct_basis_lut u_basis_lut (
    .k1     (k[5:3]),
    .k2     (k[2:0]),
    .n1     (out_idx[5:3]),
    .n2     (out_idx[2:0]),
    .weight (weight)
  );

  assign product     = coef_buf[k] * weight;
  assign product_ext = {{(ACC_W - PROD_W){product[PROD_W-1]}}, product};

  assign coef_accept = bus.coef_valid && coef_ready_c;
  assign pix_xfer    = pix_valid_q && bus.pix_ready;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= next_state;
  end

  always_comb begin
    next_state   = state;
    coef_ready_c = 1'b0;
    busy_c       = 1'b1;
    case (state)
      LOAD: begin
        coef_ready_c = 1'b1;
        busy_c       = 1'b0;
        if (coef_accept && load_idx == LAST_IDX) next_state = MAC;
      end
      MAC: begin
        if (k == LAST_IDX) next_state = EMIT;
      end
      EMIT: begin
        if (pix_xfer) next_state = (out_idx == LAST_IDX) ? LOAD : MAC;
      end
      default: next_state = LOAD;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_idx    <= '0;
      out_idx     <= '0;
      k           <= '0;
      acc         <= '0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (coef_accept) begin
            load_idx <= load_idx + 6'd1;
            if (load_idx == LAST_IDX) begin
              k   <= '0;
              acc <= '0;
            end
          end
        end
        MAC: begin
          acc <= acc + product_ext;
          k   <= k + 6'd1;
        end
        EMIT: begin
          if (!pix_valid_q) begin
            pix_valid_q <= 1'b1;
            pix_data_q  <= to_pixel(acc);
          end else if (bus.pix_ready) begin
            pix_valid_q <= 1'b0;
            acc         <= '0;
            k           <= '0;
            if (out_idx == LAST_IDX) begin
              out_idx  <= '0;
              load_idx <= '0;
            end else begin
              out_idx <= out_idx + 6'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Buffer contents are don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (coef_accept) coef_buf[load_idx] <= bus.coef_data;
  end

  assign bus.coef_ready = coef_ready_c;
  assign bus.pix_valid  = pix_valid_q;
  assign bus.pix_data   = pix_data_q;
  assign busy           = busy_c;
  assign dbg_state      = state;

endmodule

// File: tb/tb_idct_8x8_engine.sv
// ---------------------------------------------------------------------------
// tb_idct_8x8_engine
// Self-checking bench for idct_8x8_engine. Expected pixels come from a
// reference built directly on the cosine formula: an exact integer model
// using round(4096*basis) weights, plus a floating-point model (+/-1).
// ---------------------------------------------------------------------------
module tb_idct_8x8_engine;
  import idct_pkg::*;

  localparam real PI = 3.14159265358979323846;

  // ---------------- clock / reset ----------------
  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  logic   busy;
  state_t dbg_state;

  always #5 clk = ~clk;

  idct_8x8_engine_if bus ();

  idct_8x8_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int          n_compared   = 0;
  int          n_mismatched = 0;
  logic [15:0] exp_q[$];        // {float_pixel, exact_pixel}
  int          blk [64];
  int          pix_seen       = 0;
  longint      last_accept_cyc = 0;
  longint      hold_until     = 0;
  bit          rand_ready     = 1'b0;
  bit          want_latency   = 1'b0;
  bit          want_ready_after = 1'b0;
  bit          prev_stall     = 1'b0;
  logic [7:0]  prev_data      = '0;
  logic [15:0] e;
  int          diff;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic real alpha(int k);
    return (k == 0) ? $sqrt(1.0 / 8.0) : 0.5;
  endfunction

  function automatic real basis(int k1, int k2, int n1, int n2);
    return alpha(k1) * alpha(k2) * $cos((2 * n1 + 1) * k1 * PI / 16.0)
                                 * $cos((2 * n2 + 1) * k2 * PI / 16.0);
  endfunction

  function automatic longint spec_weight(int k1, int k2, int n1, int n2);
    return longint'($floor(4096.0 * basis(k1, k2, n1, n2) + 0.5));
  endfunction

  function automatic int clamp8(longint v);
    if (v < 0)   return 0;
    if (v > 255) return 255;
    return int'(v);
  endfunction

  task automatic push_expected();
    longint acc;
    real    s;
    int     ex;
    int     fl;
    for (int n = 0; n < 64; n++) begin
      acc = 0;
      s   = 0.0;
      for (int k = 0; k < 64; k++) begin
        acc += longint'(blk[k]) * spec_weight(k / 8, k % 8, n / 8, n % 8);
        s   += real'(blk[k]) * basis(k / 8, k % 8, n / 8, n % 8);
      end
      ex = clamp8(((acc + 2048) >>> 12) + 128);
      fl = clamp8(longint'($floor(s + 0.5)) + 128);
      exp_q.push_back({8'(fl), 8'(ex)});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_coef(input int d, input bit gaps);
    int t;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    bus.coef_valid = 1'b1;
    bus.coef_data  = 16'(d);
    t = 0;
    @(negedge clk);
    while (!bus.coef_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check("coef_accept_timeout", 0, 1);
    @(posedge clk); #1;
    last_accept_cyc = cyc;
    bus.coef_valid  = 1'b0;
  endtask

  task automatic send_block(input bit gaps);
    push_expected();
    for (int i = 0; i < 64; i++) send_coef(blk[i], gaps);
  endtask

  // Waits for the scoreboard to drain; optionally pulses coef_valid with
  // junk while the engine computes.
  task automatic wait_block_done(input bit junk);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 30000) begin
      if (junk) begin
        bus.coef_valid = ($urandom_range(0, 3) == 0);
        bus.coef_data  = 16'($urandom);
      end
      @(posedge clk); #1;
      t++;
    end
    bus.coef_valid = 1'b0;
    if (t >= 30000) check("block_timeout", 0, 1);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic wait_pixels(input int target);
    int t;
    t = 0;
    while (pix_seen < target && t < 20000) begin @(posedge clk); #1; t++; end
    if (t >= 20000) check("pixel_wait_timeout", pix_seen, target);
  endtask

  task automatic wait_state(input state_t s);
    int t;
    t = 0;
    while (dbg_state != s && t < 500) begin @(posedge clk); #1; t++; end
    if (t >= 500) check("state_wait_timeout", dbg_state, s);
  endtask

  task automatic clear_blk();
    for (int i = 0; i < 64; i++) blk[i] = 0;
  endtask

  task automatic random_blk();
    clear_blk();
    blk[0] = int'($urandom_range(0, 2000)) - 1000;
    for (int i = 0; i < 8; i++) blk[$urandom_range(1, 63)] = int'($urandom_range(0, 120)) - 60;
  endtask

  task automatic run_block(input bit gaps, input bit junk);
    int base;
    base = pix_seen;
    send_block(gaps);
    wait_block_done(junk);
    check("block_pixel_count", pix_seen - base, 64);
  endtask

  // ---------------- pixel_ready driver ----------------
  initial begin
    bus.pix_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (cyc < hold_until)  bus.pix_ready = 1'b0;
      else if (rand_ready)   bus.pix_ready = 1'($urandom_range(0, 1));
      else                   bus.pix_ready = 1'b1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", bus.pix_valid, 1);
          check("stall_data", bus.pix_data, prev_data);
        end
        if (want_ready_after) begin
          check("ready_after_block", bus.coef_ready, 1);
          check("busy_after_block", busy, 0);
          want_ready_after = 1'b0;
        end
        if (bus.coef_valid && busy) check("ready_while_busy", bus.coef_ready, 0);
        if (bus.pix_valid && want_latency) begin
          check("first_pixel_latency", cyc - last_accept_cyc, 65);
          want_latency = 1'b0;
        end
        if (bus.pix_valid && bus.pix_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pixel", bus.pix_data, -1);
          end else begin
            e    = exp_q.pop_front();
            diff = int'(bus.pix_data) - int'(e[15:8]);
            check("pix_exact", bus.pix_data, e[7:0]);
            check("pix_float_tol", (diff >= -1 && diff <= 1), 1);
            pix_seen++;
            if (exp_q.size() == 0) want_ready_after = 1'b1;
          end
        end
        prev_stall = bus.pix_valid && !bus.pix_ready;
        prev_data  = bus.pix_data;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at t=%0t", $time);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int seen_at_reset;
    bus.coef_valid = 1'b0;
    bus.coef_data  = '0;
    rst_n          = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("reset_state", dbg_state, LOAD);
    check("reset_coef_ready", bus.coef_ready, 1);
    check("reset_pix_valid", bus.pix_valid, 0);
    check("reset_pix_data", bus.pix_data, 0);
    check("reset_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // all-zero block, back-to-back coefficients, latency check
    clear_blk();
    want_latency = 1'b1;
    run_block(1'b0, 1'b0);

    // DC only: 80, upper clamp, lower clamp
    clear_blk(); blk[0] = 80;    run_block(1'b0, 1'b0);
    clear_blk(); blk[0] = 2047;  run_block(1'b0, 1'b0);
    clear_blk(); blk[0] = -2048; run_block(1'b1, 1'b0);

    // X[1][0] = 64: vertical first harmonic
    clear_blk(); blk[8] = 64;    run_block(1'b0, 1'b0);

    // random blocks, random backpressure, junk coef_valid during compute
    rand_ready = 1'b1;
    repeat (2) begin
      random_blk();
      run_block(1'b1, 1'b1);
    end

    // long stall: hold pix_ready low 20 cycles while a pixel is waiting
    random_blk();
    begin
      int base;
      base = pix_seen;
      send_block(1'b0);
      wait_pixels(base + 30);
      wait_state(MAC);
      wait_state(EMIT);
      hold_until = cyc + 21;
      wait_block_done(1'b1);
      check("stall_block_pixel_count", pix_seen - base, 64);
    end
    rand_ready = 1'b0;

    // reset asserted during MAC of pixel 10
    random_blk();
    begin
      int base;
      base = pix_seen;
      send_block(1'b0);
      wait_pixels(base + 10);
      wait_state(MAC);
      repeat (20) begin @(posedge clk); #1; end
      check("pre_reset_state", dbg_state, MAC);
      rst_n = 1'b0;
      #1;
      check("midreset_pix_valid", bus.pix_valid, 0);
      check("midreset_coef_ready", bus.coef_ready, 1);
      check("midreset_busy", busy, 0);
      exp_q.delete();
      seen_at_reset = pix_seen;
      repeat (3) begin @(posedge clk); #1; end
      rst_n = 1'b1;
      repeat (150) begin @(posedge clk); #1; end
      check("no_pixels_after_reset", pix_seen - seen_at_reset, 0);
      check("idle_after_reset", dbg_state, LOAD);
    end

    // a full block decodes correctly after the aborted one
    random_blk();
    run_block(1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
